arbiter_rr: RTL and testbench

//  N-requester arbiter; successor to the 2-port grant FSM.
//  - Selection policy: parametrised, fixed-priority or round-robin.
//  - Grant stays with its holder while the request is held.
//  - Optional hold limit preempts a long holder when others are waiting.
//  - On release, grant hands off directly to the next requester with no idle bubble.
//  - Sits between bus masters and a shared slave/resource.

---
 rtl/arbiter_rr_pkg.sv | 14 +
 rtl/arbiter_rr_if.sv | 13 +
 rtl/rr_pick.sv | 33 +++
 rtl/arbiter_rr.sv | 108 ++++++++++
 tb/tb_arbiter_rr.sv | 115 +++++++++++
 5 files changed

// File: rtl/arbiter_rr_pkg.sv
// Shared types and helpers for the N-requester arbiter.
package arbiter_rr_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;
  typedef enum bit {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;

  // Index of a one-hot word; OR-reduction of set positions (0 for all-zero).
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) idx = idx | 5'(i);
    return idx;
  endfunction
endpackage

// File: rtl/arbiter_rr_if.sv
// Request/grant bundle between the bus masters and the arbiter.
interface arbiter_rr_if #(parameter int N = 4) ();
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           preempt;

  modport master (output req, input gnt, gnt_valid, gnt_id, preempt);
  modport slave  (input req, output gnt, gnt_valid, gnt_id, preempt);
endinterface

// File: rtl/rr_pick.sv
// Combinational priority encoder: fixed (index 0 first) or rotating after 'last'.
module rr_pick
  import arbiter_rr_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = 1,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_mask,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   win_onehot,
  output logic [IDW-1:0] win_id,
  output logic           win_any
);

  always_comb begin
    logic [IDW-1:0] idx;
    win_onehot = '0;
    win_id     = '0;
    win_any    = 1'b0;
    idx        = '0;
    for (int i = 0; i < N; i++) begin
      if (MODE == int'(ARB_RR)) idx = IDW'((int'(last) + 1 + i) % N);
      else                      idx = IDW'(i);
      if (!win_any && req_mask[idx]) begin
        win_any         = 1'b1;
        win_onehot[idx] = 1'b1;
        win_id          = idx;
      end
    end
  end

endmodule

// File: rtl/arbiter_rr.sv
// N-requester arbiter: grant held while requested, direct handoff, optional hold limit.
module arbiter_rr
  import arbiter_rr_pkg::*;
#(
  parameter int N        = 4,
  parameter int MODE     = 1,
  parameter int HOLD_MAX = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  arbiter_rr_if.slave  bus
);
  localparam int IDW = $clog2(N);
  localparam int CW  = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  arb_state_t     state, state_n;
  logic [N-1:0]   gnt, gnt_n, req, mask, win_onehot;
  logic [IDW-1:0] gnt_id, gnt_id_n, last, last_n, win_id;
  logic [CW-1:0]  hold_cnt, hold_cnt_n;
  logic           preempt, preempt_n, gnt_valid, win_any, holder_req, hold_hit;

  assign req = bus.req;
  // In GRANT, last always equals the holder, so one encoder serves both states.
  assign mask       = (state == GRANT) ? (req & ~gnt) : req;
  assign holder_req = |(req & gnt);
  assign hold_hit   = (HOLD_MAX != 0) && (hold_cnt == CNT_TOP);

  rr_pick #(.N(N), .MODE(MODE)) u_pick (
    .req_mask  (mask),
    .last      (last),
    .win_onehot(win_onehot),
    .win_id    (win_id),
    .win_any   (win_any)
  );

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    gnt_id_n   = gnt_id;
    last_n     = last;
    hold_cnt_n = hold_cnt;
    preempt_n  = 1'b0;
    case (state)
      IDLE: begin
        if (win_any) begin
          state_n    = GRANT;
          gnt_n      = win_onehot;
          gnt_id_n   = win_id;
          last_n     = win_id;
          hold_cnt_n = '0;
        end
      end
      GRANT: begin
        if (!holder_req || (hold_hit && win_any)) begin
          if (win_any) begin
            gnt_n      = win_onehot;
            gnt_id_n   = win_id;
            last_n     = win_id;
            preempt_n  = holder_req;
          end else begin
            state_n    = IDLE;
            gnt_n      = '0;
            gnt_id_n   = '0;
          end
          hold_cnt_n = '0;
        end else if (HOLD_MAX != 0 && !hold_hit) begin
          hold_cnt_n = hold_cnt + CW'(1);
        end
      end
      default: begin
        state_n    = IDLE;
        gnt_n      = '0;
        gnt_id_n   = '0;
        hold_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      hold_cnt  <= '0;
      last      <= IDW'(N - 1);
      preempt   <= 1'b0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gnt_valid <= |gnt_n;
      gnt_id    <= gnt_id_n;
      hold_cnt  <= hold_cnt_n;
      last      <= last_n;
      preempt   <= preempt_n;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.gnt_valid = gnt_valid;
  assign bus.gnt_id    = gnt_id;
  assign bus.preempt   = preempt;

  a_gnt_consistent: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(gnt) && (!gnt_valid || gnt_id == IDW'(onehot_to_idx(32'(gnt)))));

endmodule

// File: tb/tb_arbiter_rr.sv
// Table-driven check of three arbiter configurations (RR, fixed, RR with hold limit 3).
module tb_arbiter_rr;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  arbiter_rr_if #(.N(4)) bus_rr ();
  arbiter_rr_if #(.N(4)) bus_fp ();
  arbiter_rr_if #(.N(4)) bus_hm ();

  arbiter_rr #(.N(4), .MODE(1), .HOLD_MAX(0)) dut_rr (.clock(clock), .reset_n(reset_n), .bus(bus_rr));
  arbiter_rr #(.N(4), .MODE(0), .HOLD_MAX(0)) dut_fp (.clock(clock), .reset_n(reset_n), .bus(bus_fp));
  arbiter_rr #(.N(4), .MODE(1), .HOLD_MAX(3)) dut_hm (.clock(clock), .reset_n(reset_n), .bus(bus_hm));

  typedef struct { int dut; logic [3:0] req; logic [3:0] gnt; logic pre; string name; } vec_t;
  typedef struct { int dut; logic [3:0] gnt; logic pre; string name; } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic sample(input int d, output logic [3:0] g, output logic v,
                        output logic [1:0] id, output logic p);
    case (d)
      0:       begin g = bus_rr.gnt; v = bus_rr.gnt_valid; id = bus_rr.gnt_id; p = bus_rr.preempt; end
      1:       begin g = bus_fp.gnt; v = bus_fp.gnt_valid; id = bus_fp.gnt_id; p = bus_fp.preempt; end
      default: begin g = bus_hm.gnt; v = bus_hm.gnt_valid; id = bus_hm.gnt_id; p = bus_hm.preempt; end
    endcase
  endtask

  task automatic check_all(input string tag, input int d, input logic [3:0] eg, input logic ep);
    logic [3:0] g;
    logic       v, p;
    logic [1:0] id;
    sample(d, g, v, id, p);
    check({tag, ".gnt"},     32'(g),  32'(eg));
    check({tag, ".valid"},   32'(v),  32'(|eg));
    check({tag, ".id"},      32'(id), 32'(idx_of(eg)));
    check({tag, ".preempt"}, 32'(p),  32'(ep));
  endtask

  task automatic drive(input int d, input logic [3:0] r);
    bus_rr.req = (d == 0) ? r : 4'h0;
    bus_fp.req = (d == 1) ? r : 4'h0;
    bus_hm.req = (d == 2) ? r : 4'h0;
  endtask

  initial begin
    exp_t e;
    // Expected outputs after the edge that samples each req value.
    vecs = '{
      '{0, 4'hF, 4'h1, 1'b0, "rr_first"},  '{0, 4'hE, 4'h2, 1'b0, "rr_rot1"},
      '{0, 4'hD, 4'h4, 1'b0, "rr_rot2"},   '{0, 4'hB, 4'h8, 1'b0, "rr_rot3"},
      '{0, 4'h7, 4'h1, 1'b0, "rr_wrap"},   '{0, 4'h0, 4'h0, 1'b0, "rr_idle"},
      '{0, 4'h8, 4'h8, 1'b0, "pulse_a"},   '{0, 4'h8, 4'h8, 1'b0, "pulse_b"},
      '{0, 4'h0, 4'h0, 1'b0, "pulse_end"}, '{0, 4'h9, 4'h1, 1'b0, "rr_after3"},
      '{1, 4'hA, 4'h2, 1'b0, "fp_first"},  '{1, 4'hA, 4'h2, 1'b0, "fp_hold"},
      '{1, 4'h8, 4'h8, 1'b0, "fp_handoff"},'{1, 4'hA, 4'h8, 1'b0, "fp_keep1"},
      '{1, 4'hA, 4'h8, 1'b0, "fp_keep2"},  '{1, 4'h2, 4'h2, 1'b0, "fp_back"},
      '{1, 4'h0, 4'h0, 1'b0, "fp_idle"},   '{1, 4'hF, 4'h1, 1'b0, "fp_lowest"},
      '{2, 4'h4, 4'h4, 1'b0, "hm_c0"},     '{2, 4'h5, 4'h4, 1'b0, "hm_c1"},
      '{2, 4'h5, 4'h4, 1'b0, "hm_c2"},     '{2, 4'h5, 4'h1, 1'b1, "hm_preempt"},
      '{2, 4'h5, 4'h1, 1'b0, "hm_after1"}, '{2, 4'h5, 4'h1, 1'b0, "hm_after2"},
      '{2, 4'h4, 4'h4, 1'b0, "hm_drop_at_limit"}, '{2, 4'h0, 4'h0, 1'b0, "hm_idle"},
      '{2, 4'h2, 4'h2, 1'b0, "hm_s0"},     '{2, 4'h2, 4'h2, 1'b0, "hm_s1"},
      '{2, 4'h2, 4'h2, 1'b0, "hm_s2"},     '{2, 4'h2, 4'h2, 1'b0, "hm_sat"},
      '{2, 4'h3, 4'h1, 1'b1, "hm_sat_preempt"}, '{2, 4'h4, 4'h4, 1'b0, "hm_mid"}
    };

    bus_rr.req = 4'hF; bus_fp.req = 4'hF; bus_hm.req = 4'hF;
    repeat (2) begin
      @(posedge clock); #1;
      for (int d = 0; d < 3; d++) check_all("reset", d, 4'h0, 1'b0);
    end

    foreach (vecs[k]) begin
      @(negedge clock);
      drive(vecs[k].dut, vecs[k].req);
      if (k == 0) reset_n = 1'b1;
      sb.push_back('{vecs[k].dut, vecs[k].gnt, vecs[k].pre, vecs[k].name});
      @(posedge clock); #1;
      if (sb.size() == 0) begin
        n_assert++; n_fail++;
        $display("FAIL scoreboard: got empty queue, expected entry");
      end else begin
        e = sb.pop_front();
        check_all(e.name, e.dut, e.gnt, e.pre);
      end
    end

    // Reset asserted between edges while dut_hm holds 0100.
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check_all("async_rst", d, 4'h0, 1'b0);
    @(posedge clock); #1;
    check_all("async_rst_hold", 2, 4'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
